// File: rtl/bubble_write_capture_pkg.sv
// Shared bubble-memory parameters: position/page geometry, capture timing
// defaults and the capture FSM state encoding.
// No ports (package).
package bubble_write_capture_pkg;

  // Position converter / page geometry
  localparam int BUBBLE_POSITION_W = 12;
  localparam int BUBBLE_PAGE_BITS  = 1024;
  localparam int BUBBLE_PAGE_BYTES = BUBBLE_PAGE_BITS / 8;

  // Capture timing defaults
  localparam int BUBBLE_PREAMBLE_LENGTH = 100;
  localparam int BUBBLE_PAGE_DIBITS     = BUBBLE_PAGE_BITS / 2;
  localparam int BUBBLE_BUF_ADDR_W      = 9;

  typedef enum logic [1:0] {
    CAP_IDLE     = 2'd0,
    CAP_PREAMBLE = 2'd1,
    CAP_CAPTURE  = 2'd2,
    CAP_DONE     = 2'd3
  } capture_state_e;

  // Host lines are active low (0 = bubble); the buffer stores 1 = bubble.
  function automatic logic [1:0] dibit_from_lines(input logic odd_n, input logic even_n);
    return {~odd_n, ~even_n};
  endfunction

endpackage

// File: rtl/bubble_write_capture_if.sv
// Host-side and flash-writer-side signals of the bubble write capture block.
//   master: host / flash writer (drives window, strobe, data, ack, read address)
//   slave : capture block (drives capture_active, page_ready, page_number,
//           buffer_read_data, overrun)
interface bubble_write_capture_if;
  import bubble_write_capture_pkg::*;

  logic                         bubble_interface_enable;
  logic                         write_gate;
  logic                         coil_run;
  logic                         data_in_strobe;
  logic                         bubble_in_odd;
  logic                         bubble_in_even;
  logic [BUBBLE_POSITION_W-1:0] bubble_page_input;
  logic                         capture_active;
  logic                         page_ready;
  logic [BUBBLE_POSITION_W-1:0] page_number;
  logic                         page_ack;
  logic [BUBBLE_BUF_ADDR_W-1:0] buffer_read_address;
  logic [1:0]                   buffer_read_data;
  logic                         overrun;

  modport master (
    output bubble_interface_enable, write_gate, coil_run, data_in_strobe,
           bubble_in_odd, bubble_in_even, bubble_page_input, page_ack,
           buffer_read_address,
    input  capture_active, page_ready, page_number, buffer_read_data, overrun
  );

  modport slave (
    input  bubble_interface_enable, write_gate, coil_run, data_in_strobe,
           bubble_in_odd, bubble_in_even, bubble_page_input, page_ack,
           buffer_read_address,
    output capture_active, page_ready, page_number, buffer_read_data, overrun
  );

endinterface

// File: rtl/bubble_capture_buffer.sv
// Page buffer: DEPTH x 2-bit RAM, one write port and one registered read
// port (1-cycle latency, read-first on address collision).
// Ports:
//   clk            clock
//   reset          sync active-high; clears the read register only
//   write_enable   write strobe
//   write_address  write address
//   write_data     dibit {odd, even}, 1 = bubble
//   read_address   read address
//   read_data      registered read data
module bubble_capture_buffer #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [1:0]        write_data,
  input  logic [ADDR_W-1:0] read_address,
  output logic [1:0]        read_data
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_enable) mem[write_address] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) read_data <= '0;
    else       read_data <= mem[read_address];
  end

endmodule

// File: rtl/bubble_write_capture.sv
// Captures one page of host write data into a local buffer for the flash
// writer. After the write window opens, PREAMBLE_LENGTH strobes are skipped,
// then PAGE_DIBITS dibits are stored; the page is then held until page_ack.
// Ports:
//   master_clock  sole clock, rising edge
//   reset         synchronous, active high
//   bus           bubble_write_capture_if.slave (host + flash writer side)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a write window to open
// PREAMBLE | window open, counting (and discarding) preamble strobes
// CAPTURE  | storing one dibit per strobe into the buffer
// DONE     | page complete, held for the flash writer until page_ack
module bubble_write_capture
  import bubble_write_capture_pkg::*;
#(
  parameter int PREAMBLE_LENGTH = BUBBLE_PREAMBLE_LENGTH,
  parameter int PAGE_DIBITS     = BUBBLE_PAGE_DIBITS
) (
  input logic                   master_clock,
  input logic                   reset,
  bubble_write_capture_if.slave bus
);

  // One counter serves both phases, so it must hold the larger of the two.
  localparam int CNT_W = BUBBLE_BUF_ADDR_W + 1;
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LENGTH - 1);
  localparam logic [CNT_W-1:0] PAGE_LAST = CNT_W'(PAGE_DIBITS - 1);

  capture_state_e               state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         strobe_q;
  logic                         window_q;
  logic                         page_ready_q;
  logic                         overrun_q;
  logic [BUBBLE_POSITION_W-1:0] page_number_q;

  logic       window;
  logic       window_start;
  logic       sample_event;
  logic       latch_page;
  logic       buf_we;
  logic       overrun_set;
  logic [1:0] wr_dibit;

  assign window       = bus.write_gate & bus.coil_run & ~bus.bubble_interface_enable;
  assign window_start = window & ~window_q;
  assign sample_event = bus.data_in_strobe & ~strobe_q;
  assign wr_dibit     = dibit_from_lines(bus.bubble_in_odd, bus.bubble_in_even);

  always_ff @(posedge master_clock) begin
    if (reset) state_q <= CAP_IDLE;
    else       state_q <= state_d;
  end

  // Losing the window takes priority over a coincident strobe, so a sample
  // landing on an abort cycle is never written.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_page  = 1'b0;
    buf_we      = 1'b0;
    overrun_set = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (window_start) begin
          // page_ready lags DONE by a cycle, so a page may still be
          // pending for one cycle after the ack.
          if (page_ready_q) begin
            overrun_set = 1'b1;
          end else begin
            state_d    = CAP_PREAMBLE;
            cnt_d      = '0;
            latch_page = 1'b1;
          end
        end
      end
      CAP_PREAMBLE: begin
        if (!window) begin
          state_d = CAP_IDLE;
        end else if (sample_event) begin
          if (cnt_q == PRE_LAST) begin
            state_d = CAP_CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CAP_CAPTURE: begin
        if (!window) begin
          state_d = CAP_IDLE;
        end else if (sample_event) begin
          buf_we = 1'b1;
          if (cnt_q == PAGE_LAST) state_d = CAP_DONE;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      CAP_DONE: begin
        if (window_start) overrun_set = 1'b1;
        if (bus.page_ack) state_d = CAP_IDLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      cnt_q         <= '0;
      strobe_q      <= 1'b0;
      window_q      <= 1'b0;
      page_ready_q  <= 1'b0;
      overrun_q     <= 1'b0;
      page_number_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      strobe_q     <= bus.data_in_strobe;
      window_q     <= window;
      page_ready_q <= (state_q == CAP_DONE);
      if (overrun_set) overrun_q <= 1'b1;
      if (latch_page)  page_number_q <= bus.bubble_page_input;
    end
  end

  assign bus.capture_active = (state_q == CAP_PREAMBLE) || (state_q == CAP_CAPTURE);
  assign bus.page_ready     = page_ready_q;
  assign bus.page_number    = page_number_q;
  assign bus.overrun        = overrun_q;

  bubble_capture_buffer #(
    .DEPTH  (PAGE_DIBITS),
    .ADDR_W (BUBBLE_BUF_ADDR_W)
  ) u_buffer (
    .clk           (master_clock),
    .reset         (reset),
    .write_enable  (buf_we & ~reset),
    .write_address (cnt_q[BUBBLE_BUF_ADDR_W-1:0]),
    .write_data    (wr_dibit),
    .read_address  (bus.buffer_read_address),
    .read_data     (bus.buffer_read_data)
  );

endmodule

// File: tb/tb_bubble_write_capture.sv
// Bench for bubble_write_capture: vector table, directed page sequences and
// a randomized run against an event-counting reference model.
module tb_bubble_write_capture;
  import bubble_write_capture_pkg::*;

  localparam int PRE  = 100;
  localparam int PAGE = 512;

  logic master_clock = 1'b0;
  logic reset        = 1'b1;
  always #10 master_clock = ~master_clock;

  bubble_write_capture_if bus();

  bubble_write_capture dut (
    .master_clock (master_clock),
    .reset        (reset),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts strobe events within an open window.
  bit         m_prev_strobe, m_prev_win, m_in_win, m_done, m_pr, m_ovr, m_rd_valid;
  int         m_n;
  logic [11:0] m_pn;
  logic [1:0] m_rd;
  logic [1:0] m_mem [PAGE];
  bit         m_written [PAGE];

  task automatic model_step();
    bit ev, win, ws, pr_next, rdv_next;
    logic [1:0] rd_next;
    int a;
    if (reset) begin
      m_prev_strobe = 0; m_prev_win = 0; m_in_win = 0; m_done = 0;
      m_pr = 0; m_ovr = 0; m_pn = '0; m_n = 0; m_rd = 2'b00; m_rd_valid = 1;
      return;
    end
    ev  = bus.data_in_strobe && !m_prev_strobe;
    win = bus.write_gate && bus.coil_run && !bus.bubble_interface_enable;
    ws  = win && !m_prev_win;
    a   = int'(bus.buffer_read_address);
    rd_next  = m_mem[a];
    rdv_next = m_written[a];
    pr_next  = m_done;
    if (m_done) begin
      if (ws) m_ovr = 1;
      if (bus.page_ack) m_done = 0;
    end else if (m_in_win) begin
      if (!win) m_in_win = 0;
      else if (ev) begin
        m_n++;
        if (m_n > PRE) begin
          m_mem[m_n-PRE-1]     = {~bus.bubble_in_odd, ~bus.bubble_in_even};
          m_written[m_n-PRE-1] = 1;
        end
        if (m_n == PRE + PAGE) begin
          m_in_win = 0;
          m_done   = 1;
        end
      end
    end else if (ws) begin
      if (m_pr) m_ovr = 1;
      else begin
        m_in_win = 1;
        m_n      = 0;
        m_pn     = bus.bubble_page_input;
      end
    end
    m_pr = pr_next; m_rd = rd_next; m_rd_valid = rdv_next;
    m_prev_strobe = bus.data_in_strobe;
    m_prev_win    = win;
  endtask

  task automatic compare_model();
    check("m_capture_active", 32'(bus.capture_active), 32'(m_in_win));
    check("m_page_ready", 32'(bus.page_ready), 32'(m_pr));
    check("m_overrun", 32'(bus.overrun), 32'(m_ovr));
    check("m_page_number", 32'(bus.page_number), 32'(m_pn));
    if (m_rd_valid) check("m_read_data", 32'(bus.buffer_read_data), 32'(m_rd));
  endtask

  task automatic tick();
    @(posedge master_clock);
    model_step();
    #1;
    if (cmp_en) compare_model();
  endtask

  task automatic idle_inputs();
    bus.bubble_interface_enable = 0; bus.write_gate = 0; bus.coil_run = 0;
    bus.data_in_strobe = 0; bus.bubble_in_odd = 1; bus.bubble_in_even = 1;
    bus.bubble_page_input = '0; bus.page_ack = 0; bus.buffer_read_address = '0;
  endtask

  task automatic open_window(input logic [11:0] pg);
    bus.bubble_page_input = pg;
    bus.bubble_interface_enable = 0; bus.write_gate = 1; bus.coil_run = 1;
    tick();
  endtask

  // Strobe j (1-based) carries bubble=1 on both lines during the preamble,
  // then dibit (j-PRE-1)[1:0] ^ xr.
  task automatic send_strobes(input int first, input int count, input logic [1:0] xr);
    logic [1:0] bub;
    for (int j = first; j < first + count; j++) begin
      bub = (j <= PRE) ? 2'b11 : (2'(j - PRE - 1) ^ xr);
      bus.bubble_in_odd = ~bub[1]; bus.bubble_in_even = ~bub[0];
      bus.data_in_strobe = 1; tick();
      bus.data_in_strobe = 0; tick();
    end
  endtask

  task automatic read_check(input string name, input int addr, input logic [1:0] exp);
    bus.buffer_read_address = 9'(addr);
    tick();
    check(name, 32'(bus.buffer_read_data), 32'(exp));
  endtask

  task automatic pulse_ack();
    bus.page_ack = 1; tick(); bus.page_ack = 0; tick(); tick();
  endtask

  typedef struct {
    bit rst, en, gate, coil, strb, ack;
    bit ca, pr, ov;
    string name;
  } vec_t;
  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1,0,0,0,0,0, 0,0,0, "v_reset"};
    vecs[1]  = '{0,1,1,1,0,0, 0,0,0, "v_enable_gated"};
    vecs[2]  = '{0,0,1,1,0,0, 1,0,0, "v_window_open"};
    vecs[3]  = '{0,0,1,1,0,1, 1,0,0, "v_ack_ignored"};
    vecs[4]  = '{0,0,1,1,1,0, 1,0,0, "v_strobe_preamble"};
    vecs[5]  = '{0,0,0,1,0,0, 0,0,0, "v_gate_abort"};
    vecs[6]  = '{0,0,1,1,0,0, 1,0,0, "v_reopen"};
    vecs[7]  = '{0,1,1,1,0,0, 0,0,0, "v_enable_abort"};
    vecs[8]  = '{0,0,0,0,0,0, 0,0,0, "v_idle"};
    vecs[9]  = '{0,0,1,0,0,0, 0,0,0, "v_no_coil"};
    vecs[10] = '{0,0,1,1,0,0, 1,0,0, "v_open_again"};
    vecs[11] = '{1,0,1,1,0,0, 0,0,0, "v_reset_wins"};
    vecs[12] = '{0,0,1,1,0,0, 1,0,0, "v_open_after_reset"};

    for (int i = 0; i < PAGE; i++) begin m_mem[i] = 2'b00; m_written[i] = 0; end
    idle_inputs();
    reset = 1;
    tick(); tick();
    check("reset_capture_active", 32'(bus.capture_active), 0);
    check("reset_page_ready", 32'(bus.page_ready), 0);
    check("reset_page_number", 32'(bus.page_number), 0);
    check("reset_overrun", 32'(bus.overrun), 0);
    check("reset_read_data", 32'(bus.buffer_read_data), 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      bus.bubble_interface_enable = vecs[i].en;
      bus.write_gate = vecs[i].gate; bus.coil_run = vecs[i].coil;
      bus.data_in_strobe = vecs[i].strb; bus.page_ack = vecs[i].ack;
      tick();
      check({vecs[i].name, "_ca"}, 32'(bus.capture_active), 32'(vecs[i].ca));
      check({vecs[i].name, "_pr"}, 32'(bus.page_ready), 32'(vecs[i].pr));
      check({vecs[i].name, "_ov"}, 32'(bus.overrun), 32'(vecs[i].ov));
    end

    // Normal page, page 0x123, dibit i = i[1:0]; preamble carries bubbles.
    idle_inputs(); reset = 1; tick(); reset = 0; tick();
    open_window(12'h123);
    check("normal_active", 32'(bus.capture_active), 1);
    send_strobes(1, PRE + PAGE - 1, 2'b00);
    check("normal_not_ready_early", 32'(bus.page_ready), 0);
    bus.bubble_in_odd = 0; bus.bubble_in_even = 0;
    bus.data_in_strobe = 1; tick();
    check("ready_latency_low", 32'(bus.page_ready), 0);
    check("done_inactive", 32'(bus.capture_active), 0);
    bus.data_in_strobe = 0; tick();
    check("ready_latency_high", 32'(bus.page_ready), 1);
    check("normal_page_number", 32'(bus.page_number), 32'h123);
    read_check("preamble_boundary", 0, 2'b00);
    for (int k = 0; k < PAGE; k++) read_check("readback", k, 2'(k));
    send_strobes(1, 3, 2'b01);
    read_check("extra_strobes_ignored", 2, 2'b10);

    // Overrun: second window before ack.
    bus.write_gate = 0; tick();
    bus.bubble_page_input = 12'h456; bus.write_gate = 1; tick(); tick();
    check("overrun_set", 32'(bus.overrun), 1);
    check("overrun_page_number", 32'(bus.page_number), 32'h123);
    check("overrun_ready_held", 32'(bus.page_ready), 1);
    check("overrun_inactive", 32'(bus.capture_active), 0);
    read_check("overrun_buffer", 7, 2'b11);
    bus.page_ack = 1; tick(); bus.page_ack = 0;
    check("ack_ready_lag", 32'(bus.page_ready), 1);
    tick();
    check("ack_release", 32'(bus.page_ready), 0);
    check("ack_overrun_kept", 32'(bus.overrun), 1);
    bus.write_gate = 0; tick();
    open_window(12'h456);
    send_strobes(1, PRE + PAGE, 2'b10);
    check("second_ready", 32'(bus.page_ready), 1);
    check("second_page_number", 32'(bus.page_number), 32'h456);
    read_check("second_addr5", 5, 2'b11);
    read_check("second_addr6", 6, 2'b00);
    pulse_ack();

    // Abort after strobe 300.
    bus.write_gate = 0; tick();
    open_window(12'h0AA);
    send_strobes(1, 300, 2'b00);
    bus.coil_run = 0; tick();
    check("abort_inactive", 32'(bus.capture_active), 0);
    check("abort_no_ready", 32'(bus.page_ready), 0);
    check("abort_overrun_sticky", 32'(bus.overrun), 1);

    // Enable gating: a full window with enable high does nothing.
    idle_inputs(); tick();
    bus.bubble_interface_enable = 1; bus.write_gate = 1; bus.coil_run = 1; tick();
    send_strobes(1, PRE + PAGE + 5, 2'b00);
    check("gated_inactive", 32'(bus.capture_active), 0);
    check("gated_no_ready", 32'(bus.page_ready), 0);
    bus.write_gate = 0; bus.coil_run = 0; tick();
    bus.bubble_interface_enable = 0; tick();

    // Reset at capture strobe 250.
    open_window(12'h321);
    send_strobes(1, PRE + 250, 2'b00);
    bus.buffer_read_address = 9'd3; tick(); tick();
    check("pre_reset_active", 32'(bus.capture_active), 1);
    reset = 1; tick(); reset = 0;
    check("rst_capture_active", 32'(bus.capture_active), 0);
    check("rst_page_ready", 32'(bus.page_ready), 0);
    check("rst_page_number", 32'(bus.page_number), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_read_data", 32'(bus.buffer_read_data), 0);
    bus.write_gate = 0; tick();
    open_window(12'h321);
    send_strobes(1, PRE + PAGE, 2'b00);
    check("post_reset_ready", 32'(bus.page_ready), 1);
    check("post_reset_page_number", 32'(bus.page_number), 32'h321);
    pulse_ack();

    // Randomized run against the model.
    idle_inputs(); reset = 1; tick(); reset = 0; tick();
    cmp_en = 1;
    for (int c = 0; c < 20000; c++) begin
      reset = ($urandom_range(0, 4999) == 0);
      if (bus.write_gate) begin if ($urandom_range(0, 2999) == 0) bus.write_gate = 0; end
      else if ($urandom_range(0, 4) == 0) bus.write_gate = 1;
      if (bus.coil_run) begin if ($urandom_range(0, 2999) == 0) bus.coil_run = 0; end
      else if ($urandom_range(0, 4) == 0) bus.coil_run = 1;
      if (bus.bubble_interface_enable) begin if ($urandom_range(0, 4) == 0) bus.bubble_interface_enable = 0; end
      else if ($urandom_range(0, 5999) == 0) bus.bubble_interface_enable = 1;
      bus.data_in_strobe      = 1'($urandom_range(0, 1));
      bus.bubble_in_odd       = 1'($urandom_range(0, 1));
      bus.bubble_in_even      = 1'($urandom_range(0, 1));
      bus.page_ack            = ($urandom_range(0, 19) == 0);
      bus.buffer_read_address = 9'($urandom_range(0, PAGE - 1));
      bus.bubble_page_input   = 12'($urandom_range(0, 4095));
      tick();
    end
    cmp_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
